// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial a - b, LSB first, one difference/borrow cell plus a borrow flop
module serial_subtractor #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] diff,
  output logic         bout
);
  localparam int CW = $clog2(W);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t        state;
  logic [W-1:0]  ra, rb, rd;
  logic [CW-1:0] cnt;
  logic          br;
  logic          d, br_n;
  assign d    = ra[0] ^ rb[0] ^ br;
  assign br_n = (~ra[0] & rb[0]) | (~(ra[0] ^ rb[0]) & br);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      diff  <= '0;
      bout  <= 1'b0;
      ra    <= '0;
      rb    <= '0;
      rd    <= '0;
      cnt   <= '0;
      br    <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          ra    <= a;
          rb    <= b;
          br    <= 1'b0;
          cnt   <= '0;
          busy  <= 1'b1;
          state <= SHIFT;
        end
        SHIFT: begin
          ra  <= ra >> 1;
          rb  <= rb >> 1;
          rd  <= {d, rd[W-1:1]};
          br  <= br_n;
          cnt <= cnt + CW'(1);
          if (cnt == CW'(W - 1)) begin
            diff  <= {d, rd[W-1:1]};
            bout  <= br_n;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
